sha3_block_feeder: RTL
======================

# sha3_block_feeder

Upstream feeder for the SHA3-256 hash core. It accepts a message as a byte stream, applies SHA3 padding (domain byte 0x06, final bit 0x80) and packs the bytes into 1088-bit rate blocks. It then drives the core's block handshake (block, valid, more flag) and tracks core readiness through the core's hash_next and out_valid.

## Interface
- RATE_BYTES, 136: bytes per absorb block; block width = 8*RATE_BYTES = 1088.
- DOMAIN_BYTE, 8'h06: SHA3 domain/pad-start byte.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_data  in  8  message byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  byte is the final byte of the message; messages are ≥1 byte.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- blk_data  out  1088  block to core; byte k bit b is at blk_data[1087-8k-b].
- blk_valid  out  1  registered one-cycle block strobe to core.
- blk_more  out  1  another block of this message follows; held from blk_valid until the next issue.
- hash_next  in  1  core waiting for the next block of the current message.
- out_valid  in  1  core digest strobe.
- busy  out  1  message in progress (state != FILL or cnt != 0).

## Operation
- Registers:
  - buf[1087:0].
  - cnt (8-bit, 0..136).
  - final_f: current block is the last block.
  - pad_pend: a padding-only block is owed.
  - core_idle.
  - state.
- States:
  - FILL: s_ready=1. Each accepted byte is written into byte slot cnt, then cnt++.
    - s_last at slot <135: go PAD.
    - cnt reaches 136 without s_last: go ISSUE with final_f=0.
    - s_last at slot 135 (136th byte): go ISSUE with final_f=0 and pad_pend=1.
  - PAD: one cycle. OR DOMAIN_BYTE into slot cnt and 0x80 into slot 135.
    - If cnt==135, slot 135 becomes 0x86.
    - Set final_f=1 and go ISSUE.
  - ISSUE: s_ready=0. When core_idle||hash_next: blk_valid<=1, blk_more<=!final_f, go SENT.
  - SENT: blk_valid high this cycle, and blk_data=buf is stable.
    - Next edge: blk_valid<=0, buf<=0, cnt<=0, core_idle<=0.
    - Next state: final_f ? DRAIN : pad_pend ? PAD (clear pad_pend) : FILL.
  - DRAIN: s_ready=0. On out_valid: core_idle<=1, final_f<=0, go FILL.
- blk_valid is driven only from a register, because hash_next depends combinationally on in_valid inside the core. Any combinational path from hash_next to blk_valid is forbidden.
- While the core computes a non-final block, FILL accepts bytes for the next block. Bytes already written are not disturbed.
- blk_more is stable for the core's whole compute window, because it changes only on issue.
- Reset values:
  - state=FILL, cnt=0, buf=0, final_f=0, pad_pend=0, core_idle=1.
  - blk_valid=0, blk_more=0, s_ready=1 (FILL), busy=0.

## Timing
- Issue latency, last byte accepted at cycle t (slot <135): PAD at t+1, ISSUE at t+2, blk_valid at t+3 when core_idle. When instead waiting on hash_next, blk_valid is one cycle after hash_next is first seen.
- Full non-final block, 136th byte at t: ISSUE at t+1, blk_valid at t+2 if the core is ready.
- Throughput: s_ready drops for ISSUE, SENT and (on the pad path) PAD. Minimum 2 dead cycles per block.
- hash_next and out_valid are ignored outside ISSUE and DRAIN, except that out_valid always sets core_idle.
- s_valid while s_ready=0: byte not consumed; upstream holds it.
- Reset mid-message: everything returns to reset values; the partial block is discarded. The core is reset on the same rst_n.

## Structure
- Shared package sha3_pkg:
  - RATE_BYTES, RATE_BITS=1088, DOMAIN_BYTE, PAD_END_BYTE=8'h80.
  - Feeder state enum.
  - Function byte_slot(k) returning the blk_data LSB index of byte k.
- One sub-module, sha3_byte_packer: buf, cnt, byte write, pad OR and clear. The FSM and handshake logic stay in the top.

## Test plan
- "abc" (0x61 0x62 0x63, s_last on 0x63):
  - One block: slots 0..3 = 61,62,63,06; slot 135 = 80; others 0; blk_more=0.
  - With the core attached, the digest is 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- 135-byte message of 0x00: one block, slot 135 = 0x86, blk_more=0.
- 136-byte message:
  - Block 1 carries all data with blk_more=1.
  - After hash_next, block 2 is the pad block: slot 0 = 06, slot 135 = 80, blk_more=0.
- 300-byte message: three blocks with blk_more = 1,1,0. Block 3 has slot 28 = 06.
- Backpressure: block ready with hash_next held 0 for 50 cycles -> blk_valid stays 0 and s_ready=0. blk_valid fires exactly once, one cycle after hash_next rises.
- Reset at byte 70 of a message -> all outputs return to reset values. A following "abc" produces the same block as scenario 1.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared constants, state encoding and byte-placement helpers for the SHA3-256
// block feeder. Byte k, bit b of a rate block lives at bit RATE_BITS-1-8k-b.
package sha3_pkg;

  localparam int         RATE_BYTES   = 136;
  localparam int         RATE_BITS    = 8 * RATE_BYTES;
  localparam logic [7:0] DOMAIN_BYTE  = 8'h06;
  localparam logic [7:0] PAD_END_BYTE = 8'h80;
  localparam int         CNT_W        = 8;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_PAD   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_SENT  = 3'd3,
    ST_DRAIN = 3'd4
  } feeder_state_e;

  // Lowest blk_data index occupied by byte k. Bit 0 of the byte sits at the
  // top of that 8-bit field, so the byte is stored bit-reversed.
  function automatic int unsigned byte_slot(input int unsigned k);
    return RATE_BITS - 8 - 8 * k;
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha3_byte_packer.sv
// Rate-block buffer: writes one byte per cycle into slot cnt, ORs in the SHA3
// padding bytes on request and clears the whole block after it is issued.
module sha3_byte_packer
  import sha3_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [7:0]           wr_data_i,
  input  logic                 pad_en_i,
  input  logic                 clr_en_i,
  output logic [RATE_BITS-1:0] blk_o,
  output logic [CNT_W-1:0]     cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_en_i) begin
      cnt_d = '0;
    end else if (wr_en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One register per byte slot keeps every write a constant-index update.
  genvar gi;
  generate
    for (gi = 0; gi < RATE_BYTES; gi++) begin : g_slot
      localparam int unsigned LSB = byte_slot(gi);

      logic       hit;
      logic [7:0] pad_bits;
      logic [7:0] slot_q;
      logic [7:0] slot_d;

      assign hit      = (cnt_q == CNT_W'(gi));
      assign pad_bits = (hit ? bit_rev8(DOMAIN_BYTE) : 8'h00)
                      | ((gi == RATE_BYTES - 1) ? bit_rev8(PAD_END_BYTE) : 8'h00);

      always_comb begin
        slot_d = slot_q;
        if (clr_en_i) begin
          slot_d = 8'h00;
        end else if (wr_en_i && hit) begin
          slot_d = bit_rev8(wr_data_i);
        end else if (pad_en_i) begin
          slot_d = slot_q | pad_bits;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_q <= 8'h00;
        end else begin
          slot_q <= slot_d;
        end
      end

      assign blk_o[LSB +: 8] = slot_q;
    end
  endgenerate

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sha3_block_feeder.sv
// Byte-stream to SHA3-256 rate-block feeder: pads, packs and hands blocks to
// the hash core, pacing itself on the core's hash_next / out_valid.
module sha3_block_feeder
  import sha3_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [RATE_BITS-1:0] blk_data,
  output logic                 blk_valid,
  output logic                 blk_more,
  input  logic                 hash_next,
  input  logic                 out_valid,
  output logic                 busy
);

  feeder_state_e    state_q, state_d;
  logic             final_q, final_d;
  logic             pad_pend_q, pad_pend_d;
  logic             core_idle_q, core_idle_d;
  logic             blk_valid_q, blk_valid_d;
  logic             blk_more_q, blk_more_d;

  logic             accept;
  logic             wr_en;
  logic             pad_en;
  logic             clr_en;
  logic [CNT_W-1:0] cnt;

  sha3_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (s_data),
    .pad_en_i  (pad_en),
    .clr_en_i  (clr_en),
    .blk_o     (blk_data),
    .cnt_o     (cnt)
  );

  assign s_ready = (state_q == ST_FILL);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    final_d     = final_q;
    pad_pend_d  = pad_pend_q;
    core_idle_d = core_idle_q;
    blk_valid_d = blk_valid_q;
    blk_more_d  = blk_more_q;
    wr_en       = 1'b0;
    pad_en      = 1'b0;
    clr_en      = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (cnt == CNT_W'(RATE_BYTES - 1)) begin
            // A last byte landing in the final slot leaves no room for
            // padding, so a padding-only block is owed afterwards.
            state_d    = ST_ISSUE;
            final_d    = 1'b0;
            pad_pend_d = s_last;
          end else if (s_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        pad_en  = 1'b1;
        final_d = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // hash_next only reaches a register here, never blk_valid directly.
        if (core_idle_q || hash_next) begin
          blk_valid_d = 1'b1;
          blk_more_d  = !final_q;
          state_d     = ST_SENT;
        end
      end
      ST_SENT: begin
        blk_valid_d = 1'b0;
        clr_en      = 1'b1;
        core_idle_d = 1'b0;
        if (final_q) begin
          state_d = ST_DRAIN;
        end else if (pad_pend_q) begin
          pad_pend_d = 1'b0;
          state_d    = ST_PAD;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (out_valid) begin
          final_d = 1'b0;
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    if (out_valid) begin
      core_idle_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      final_q     <= 1'b0;
      pad_pend_q  <= 1'b0;
      core_idle_q <= 1'b1;
      blk_valid_q <= 1'b0;
      blk_more_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      final_q     <= final_d;
      pad_pend_q  <= pad_pend_d;
      core_idle_q <= core_idle_d;
      blk_valid_q <= blk_valid_d;
      blk_more_q  <= blk_more_d;
    end
  end

  assign blk_valid = blk_valid_q;
  assign blk_more  = blk_more_q;
  assign busy      = (state_q != ST_FILL) || (cnt != '0);

endmodule
